bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//  Sits downstream of the switch moving-average filter and takes its
//  w_bin-bit average. Drives packed BCD digits into seven_segment_display,
//  so the display shows the average in decimal, not hex.
//  Uses a valid/ready handshake on both sides. One conversion runs at a time.
// PARAMETERS
//  w_bin     8  width of binary input
//  w_digits  3  number of BCD output digits; must satisfy 10**w_digits > 2**w_bin-1
//               (otherwise the elaboration-time $error fires)
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  rst_n      in   1             asynchronous reset, active low
//  in_valid   in   1             in_bin is valid this cycle
//  in_ready   out  1             block accepts in_bin this cycle
//  in_bin     in   w_bin         unsigned binary value to convert
//  out_valid  out  1             out_bcd holds a finished result
//  out_ready  in   1             consumer takes out_bcd this cycle
//  out_bcd    out  4*w_digits    packed BCD, digit 0 (units) in [3:0]
//  busy       out  1             conversion in progress (state SHIFT)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, out_bcd=0, out_valid=0,
//    in_ready=1 after release, busy=0, internal shift reg and counter=0.
//  - Handshakes: an input transfer happens on a posedge with
//    in_valid&in_ready. An output transfer happens on a posedge with
//    out_valid&out_ready.
//  - in_ready = (state==IDLE), combinational from state only.
//    in_valid while not IDLE is ignored, with no side effects.
//  - out_valid = (state==DONE). out_bcd changes only on the edge that
//    enters DONE. It holds stable while out_valid=1 and out_ready=0.
//  - FSM states:
//    IDLE  -> SHIFT on input transfer. Load bin_sr=in_bin, bcd_sr=0, cnt=w_bin.
//    SHIFT -> each cycle: for every 4-bit digit of bcd_sr, if >=5 add 3;
//             then shift {bcd_sr,bin_sr} left 1; cnt-=1.
//             When cnt reaches 1 the step still executes, then go to DONE
//             and register out_bcd = the shifted bcd_sr.
//    DONE  -> IDLE on output transfer. Stay in DONE otherwise.
//  - Latency: accept edge = cycle 0, SHIFT occupies cycles 1..w_bin.
//    out_valid is first high after edge w_bin (visible in cycle w_bin+1... i.e.
//    exactly w_bin clock edges after the accept edge).
//  - Throughput: at most one conversion per w_bin+2 cycles. There is no
//    accept in DONE even if out_ready=1; IDLE always intervenes.
//  - Widths: bcd_sr is 4*w_digits bits, and the add-3 is done per digit in
//    4 bits with no carry between digits. cnt is $clog2(w_bin+1) bits.
//    Given the parameter rule, no overflow can occur; the MSB shifted out
//    of bcd_sr is always 0.
//  - Boundaries:
//    in_bin=0 gives all-zero BCD after the full w_bin cycles; there is no
//    early exit.
//    in_bin=2**w_bin-1 gives the maximum decimal value.
//    rst_n low mid-SHIFT or mid-DONE aborts immediately. The result is lost
//    and out_valid drops asynchronously.
//    in_valid and out_ready both high in DONE: only the output transfers;
//    the input waits for IDLE.
// TESTING
//  1 reset, in_bin=8'd0, out_ready=1 -> out_valid after 8 edges, out_bcd=12'h000
//  2 in_bin=8'd255 -> out_bcd=12'h255. in_bin=8'd99 -> 12'h099.
//    in_bin=8'd100 -> 12'h100.
//  3 backpressure: in_bin=8'd173, out_ready=0 for 20 cycles -> out_valid
//    held, out_bcd=12'h173 stable, in_ready=0. Then out_ready=1 -> one
//    transfer, IDLE next cycle.
//  4 in_valid held high with changing in_bin during SHIFT/DONE -> inputs
//    ignored. The second value is accepted only in IDLE; results stay in order.
//  5 rst_n pulsed low in SHIFT cycle 4 of in_bin=8'd200 -> out_valid=0,
//    out_bcd=0 immediately. The next conversion of 8'd42 gives 12'h042.
//  6 exhaustive sweep 0..255 with random out_ready stalls -> every out_bcd
//    matches the reference model; latency is always 8 edges.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3)
// Ports:
//   clk       - system clock, posedge
//   rst_n     - asynchronous reset, active low
//   in_valid  - in_bin is valid this cycle
//   in_ready  - converter is idle and accepts in_bin
//   in_bin    - unsigned binary value to convert
//   out_valid - out_bcd holds a finished result
//   out_ready - consumer takes out_bcd this cycle
//   out_bcd   - packed BCD, units digit in [3:0]
//   busy      - conversion in progress
module bin_to_bcd_seq #(
    parameter int w_bin    = 8,
    parameter int w_digits = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [w_bin-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*w_digits-1:0] out_bcd,
    output logic                  busy
);
    localparam int bw = 4 * w_digits;
    localparam int cw = $clog2(w_bin + 1);

    if (10 ** w_digits <= 2 ** w_bin - 1) begin : g_bad_digits
        $error("w_digits too small to hold 2**w_bin-1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, next_state;
    logic [w_bin-1:0] bin_sr;
    logic [bw-1:0]   bcd_sr, adj, shifted;
    logic [cw-1:0]   cnt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);

    always_comb begin
        next_state = state;
        if (state == IDLE && in_valid)
            next_state = SHIFT;
        else if (state == SHIFT && cnt == cw'(1))
            next_state = DONE;
        else if (state == DONE && out_ready)
            next_state = IDLE;
    end

    // add-3 is per digit with no carry: a digit >= 5 never exceeds 4 bits after +3
    always_comb begin
        adj = bcd_sr;
        for (int i = 0; i < w_digits; i++)
            adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? bcd_sr[4*i +: 4] + 4'd3 : bcd_sr[4*i +: 4];
        shifted = {adj[bw-2:0], bin_sr[w_bin-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            out_bcd <= '0;
        end else if (state == IDLE && in_valid) begin
            bin_sr <= in_bin;
            bcd_sr <= '0;
            cnt    <= cw'(w_bin);
        end else if (state == SHIFT) begin
            bin_sr <= bin_sr << 1;
            bcd_sr <= shifted;
            cnt    <= cnt - 1'b1;
            if (cnt == cw'(1))
                out_bcd <= shifted;
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    bin_to_bcd_seq #(.w_bin(8), .w_digits(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge with the DUT idle; leaves the DUT idle at a negedge
    task automatic convert(input int v, input int stall, input bit junk);
        int n;
        logic [11:0] exp;
        exp = bcd_ref(v);
        in_valid = 1'b1;
        in_bin = 8'(v);
        out_ready = (stall == 0);
        chk("in_ready_idle", 16'(in_ready), 16'd1);
        @(negedge clk);
        chk("busy_shift", 16'(busy), 16'd1);
        chk("in_ready_shift", 16'(in_ready), 16'd0);
        in_valid = junk;
        n = 0;
        while (n < 20) begin
            if (junk) in_bin = 8'($urandom);
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk("latency", 16'(n), 16'd8);
        chk("out_bcd", 16'(out_bcd), 16'(exp));
        for (int k = 0; k < stall; k++) begin
            if (junk) in_bin = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", 16'(out_valid), 16'd1);
            chk("hold_bcd", 16'(out_bcd), 16'(exp));
            chk("hold_in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("after_xfer_valid", 16'(out_valid), 16'd0);
        chk("after_xfer_ready", 16'(in_ready), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bin = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_bcd", 16'(out_bcd), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 16'(in_ready), 16'd1);

        convert(0, 0, 1'b0);
        convert(255, 1, 1'b0);
        convert(99, 0, 1'b0);
        convert(100, 2, 1'b0);
        convert(173, 20, 1'b0);
        convert(57, 3, 1'b1);
        convert(201, 0, 1'b1);

        // abort mid-SHIFT
        in_valid = 1'b1;
        in_bin = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_shift_valid", 16'(out_valid), 16'd0);
        chk("abort_shift_bcd", 16'(out_bcd), 16'd0);
        chk("abort_shift_busy", 16'(busy), 16'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_shift_ready", 16'(in_ready), 16'd1);
        convert(42, 0, 1'b0);

        // abort in DONE
        in_valid = 1'b1;
        in_bin = 8'd137;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_valid", 16'(out_valid), 16'd1);
        chk("pre_abort_bcd", 16'(out_bcd), 16'h137);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done_valid", 16'(out_valid), 16'd0);
        chk("abort_done_bcd", 16'(out_bcd), 16'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 256; v++)
            convert(v, int'($urandom_range(0, 3)), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
